// File: rtl/task_sched.sv
// task_sched: round-robin arbiter feeding one shared, single-threaded task
// engine. A grant holds the task's ack bit high for the whole execution and
// drops it on engine done or watchdog expiry, which retires the task in the
// task register. A one-cycle RELEASE state keeps ack low long enough for the
// task register to clear req before the next arbitration.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no task running; arbitrate over req & en
//   BUSY    | task task_id running; ack held, watchdog counting
//   RELEASE | ack dropped, busy still high; one cycle, then back to IDLE

module task_sched #(
    parameter int                 N_TASK    = 16,
    parameter int                 TMO_W     = 16,
    parameter logic [TMO_W-1:0]   P_TIMEOUT = 16'd50000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N_TASK-1:0] req_i,
    input  logic [N_TASK-1:0] en_i,
    output logic [N_TASK-1:0] ack_o,
    output logic              start_o,
    output logic [3:0]        task_id_o,
    output logic              busy_o,
    input  logic              done_i,
    output logic              abort_o,
    output logic              tmo_err_o,
    output logic [3:0]        tmo_id_o,
    input  logic              err_clr_i
);

    localparam int ID_W = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [TMO_W-1:0] TMO_LAST = P_TIMEOUT - 1'b1;
    localparam logic [N_TASK-1:0] ONE_HOT0 = {{(N_TASK-1){1'b0}}, 1'b1};

    logic [1:0]        state_q,   state_d;
    logic [N_TASK-1:0] ack_q,     ack_d;
    logic              start_q,   start_d;
    logic              abort_q,   abort_d;
    logic              busy_q,    busy_d;
    logic [ID_W-1:0]   task_id_q, task_id_d;
    logic              tmo_err_q, tmo_err_d;
    logic [ID_W-1:0]   tmo_id_q,  tmo_id_d;
    logic [ID_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [TMO_W-1:0]  cnt_q,     cnt_d;

    logic [N_TASK-1:0] cand;
    logic [ID_W-1:0]   cand_idx;
    logic [ID_W-1:0]   sel;
    logic              found;
    logic              done_ok;
    logic              tmo_hit;

    assign cand = req_i & en_i;

    // Rotating search: first eligible task after rr_ptr, wrapping 15 -> 0,
    // so the last granted task is the lowest priority next round.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        cand_idx = '0;
        for (int i = 1; i <= N_TASK; i++) begin
            cand_idx = rr_ptr_q + ID_W'(i);
            if (!found && cand[cand_idx]) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
    end

    // done is not accepted in the start cycle; done beats a coincident timeout.
    assign done_ok = (state_q == S_BUSY) && !start_q && done_i;
    assign tmo_hit = (state_q == S_BUSY) && (P_TIMEOUT != '0) &&
                     (cnt_q == TMO_LAST) && !done_ok;

    // Next-state and output logic for the arbitration / execution sequence.
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        busy_d    = busy_q;
        task_id_d = task_id_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        tmo_id_d  = tmo_id_q;
        tmo_err_d = tmo_err_q;

        if (err_clr_i) begin
            tmo_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ack_d     = ONE_HOT0 << sel;
                    start_d   = 1'b1;
                    task_id_d = sel;
                    rr_ptr_d  = sel;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done_ok) begin
                    ack_d   = '0;
                    state_d = S_RELEASE;
                end else if (tmo_hit) begin
                    ack_d     = '0;
                    abort_d   = 1'b1;
                    tmo_err_d = 1'b1;
                    tmo_id_d  = task_id_q;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                ack_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops ack at once so an interrupted task retires.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            ack_q     <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            task_id_q <= '0;
            tmo_err_q <= 1'b0;
            tmo_id_q  <= '0;
            rr_ptr_q  <= 4'd15;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            task_id_q <= task_id_d;
            tmo_err_q <= tmo_err_d;
            tmo_id_q  <= tmo_id_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ack_o     = ack_q;
    assign start_o   = start_q;
    assign abort_o   = abort_q;
    assign busy_o    = busy_q;
    assign task_id_o = task_id_q;
    assign tmo_err_o = tmo_err_q;
    assign tmo_id_o  = tmo_id_q;

endmodule

// File: tb/tb_task_sched.sv
// Bench for task_sched: per-cycle vector table for arbitration, masking and
// done handling, then hand-written sequences for watchdog, done/timeout
// collision, asynchronous reset and round-robin order.

module tb_task_sched;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] req_i = '0;
    logic [15:0] en_i = 16'hFFFF;
    logic [15:0] ack_o;
    logic        start_o;
    logic [3:0]  task_id_o;
    logic        busy_o;
    logic        done_i = 1'b0;
    logic        abort_o;
    logic        tmo_err_o;
    logic [3:0]  tmo_id_o;
    logic        err_clr_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task_sched #(.N_TASK(16), .TMO_W(16), .P_TIMEOUT(16'd8)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (req_i),
        .en_i      (en_i),
        .ack_o     (ack_o),
        .start_o   (start_o),
        .task_id_o (task_id_o),
        .busy_o    (busy_o),
        .done_i    (done_i),
        .abort_o   (abort_o),
        .tmo_err_o (tmo_err_o),
        .tmo_id_o  (tmo_id_o),
        .err_clr_i (err_clr_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] req;
        logic [15:0] en;
        logic        done;
        logic [15:0] ack;
        logic        start;
        logic        busy;
        logic [3:0]  id;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] r, input logic [15:0] e, input logic d,
                                input logic [15:0] a, input logic s, input logic b,
                                input logic [3:0] id);
        vec_t v;
        v.req = r; v.en = e; v.done = d; v.ack = a; v.start = s; v.busy = b; v.id = id;
        return v;
    endfunction

    task automatic chk(input string nm, input logic ok, input string act, input string exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s expected %s", nm, act, exp);
        end
    endtask

    function automatic string outs();
        return $sformatf("ack=%h start=%b busy=%b id=%0d abort=%b err=%b tmo_id=%0d",
                         ack_o, start_o, busy_o, task_id_o, abort_o, tmo_err_o, tmo_id_o);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Run one task into the watchdog; optionally pulse err_clr in the expiry cycle.
    task automatic wd_run(input int id, input logic clr_last);
        logic [15:0] oh;
        oh = 16'h0001 << id;
        req_i = oh;
        tick();
        chk("wd_grant", start_o && ack_o == oh && task_id_o == 4'(id), outs(),
            $sformatf("start=1 ack=%h id=%0d", oh, id));
        req_i = '0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("wd_hold", ack_o == oh && !abort_o && busy_o && !start_o, outs(),
                $sformatf("ack=%h abort=0 busy=1 (busy cycle %0d)", oh, k));
        end
        err_clr_i = clr_last;
        tick();
        err_clr_i = 1'b0;
        chk("wd_expire", ack_o == 16'h0 && abort_o && busy_o && tmo_err_o && tmo_id_o == 4'(id),
            outs(), $sformatf("ack=0 abort=1 busy=1 err=1 tmo_id=%0d", id));
        tick();
        chk("wd_after", !abort_o && !busy_o && ack_o == 16'h0 && tmo_err_o, outs(),
            "ack=0 abort=0 busy=0 err=1");
    endtask

    initial begin
        int exp_rr[5];
        int last_s;
        int waited;
        logic [15:0] oh;

        // Single task, stale req for one cycle after the ack falling edge.
        vecs.push_back(mk(16'h0004, 16'hFFFF, 0, 16'h0004, 1, 1, 2));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 16'h0004, 0, 1, 2));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 16'h0004, 0, 1, 2));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 16'h0004, 0, 1, 2));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 16'h0004, 0, 1, 2));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 16'h0000, 0, 1, 2));
        vecs.push_back(mk(16'h0004, 16'hFFFF, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 16'h0000, 0, 0, 0));
        // done in the start cycle is ignored.
        vecs.push_back(mk(16'h0008, 16'hFFFF, 0, 16'h0008, 1, 1, 3));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 16'h0008, 0, 1, 3));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 16'h0000, 0, 1, 3));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 16'h0000, 0, 0, 0));
        // Enable mask: task 0 stays pending until enabled.
        vecs.push_back(mk(16'h0003, 16'h0002, 0, 16'h0002, 1, 1, 1));
        vecs.push_back(mk(16'h0001, 16'h0002, 0, 16'h0002, 0, 1, 1));
        vecs.push_back(mk(16'h0001, 16'h0002, 1, 16'h0000, 0, 1, 1));
        vecs.push_back(mk(16'h0001, 16'h0002, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(16'h0001, 16'h0002, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(16'h0001, 16'hFFFF, 0, 16'h0001, 1, 1, 0));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 16'h0001, 0, 1, 0));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 1, 16'h0000, 0, 1, 0));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 0, 16'h0000, 0, 0, 0));

        #2;
        chk("reset_vals", ack_o == 16'h0 && !start_o && !busy_o && !abort_o && task_id_o == 4'd0
            && !tmo_err_o && tmo_id_o == 4'd0, outs(), "all zero");
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        foreach (vecs[i]) begin
            req_i  = vecs[i].req;
            en_i   = vecs[i].en;
            done_i = vecs[i].done;
            tick();
            chk($sformatf("vec%0d", i),
                ack_o == vecs[i].ack && start_o == vecs[i].start && busy_o == vecs[i].busy
                && !abort_o && !tmo_err_o && (!vecs[i].busy || task_id_o == vecs[i].id),
                outs(),
                $sformatf("ack=%h start=%b busy=%b id=%0d abort=0 err=0",
                          vecs[i].ack, vecs[i].start, vecs[i].busy, vecs[i].id));
        end
        done_i = 1'b0;
        en_i   = 16'hFFFF;

        // Watchdog, error clear, and clear colliding with a new timeout.
        wd_run(4, 1'b0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("err_clr", !tmo_err_o && tmo_id_o == 4'd4, outs(), "err=0 tmo_id=4");
        wd_run(5, 1'b0);
        wd_run(6, 1'b1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("err_clr2", !tmo_err_o && tmo_id_o == 4'd6, outs(), "err=0 tmo_id=6");

        // done on the 8th busy cycle beats the watchdog.
        req_i = 16'h0200;
        tick();
        chk("coll_grant", start_o && ack_o == 16'h0200 && task_id_o == 4'd9, outs(),
            "start=1 ack=0200 id=9");
        req_i = '0;
        repeat (7) tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("coll_release", ack_o == 16'h0 && !abort_o && !tmo_err_o && busy_o, outs(),
            "ack=0 abort=0 err=0 busy=1");
        tick();
        chk("coll_idle", !busy_o && !abort_o && !tmo_err_o && tmo_id_o == 4'd6, outs(),
            "busy=0 abort=0 err=0 tmo_id=6");

        // Asynchronous reset mid-task.
        req_i = 16'h0100;
        tick();
        chk("rst_grant", start_o && ack_o == 16'h0100 && task_id_o == 4'd8, outs(),
            "start=1 ack=0100 id=8");
        req_i = '0;
        tick();
        rst_n_i = 1'b0;
        #2;
        chk("async_rst", ack_o == 16'h0 && !busy_o && !start_o, outs(), "ack=0 busy=0 start=0");
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        req_i = 16'hFFFF;
        tick();
        chk("rst_ptr", start_o && ack_o == 16'h0001 && task_id_o == 4'd0, outs(),
            "start=1 ack=0001 id=0");
        req_i = '0;
        tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        tick();

        // Round-robin from a fresh reset with req held.
        rst_n_i = 1'b0;
        #2;
        rst_n_i = 1'b1;
        tick();
        exp_rr[0] = 0; exp_rr[1] = 8; exp_rr[2] = 15; exp_rr[3] = 0; exp_rr[4] = 8;
        last_s = -100;
        req_i = 16'h8101;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (!start_o && waited < 20) begin
                tick();
                waited++;
            end
            if (!start_o) begin
                chk($sformatf("rr_wait%0d", g), 1'b0, "no start in 20 cycles", "start");
            end else begin
                oh = 16'h0001 << exp_rr[g];
                chk($sformatf("rr_order%0d", g), task_id_o == 4'(exp_rr[g]) && ack_o == oh,
                    outs(), $sformatf("id=%0d ack=%h", exp_rr[g], oh));
                if (g > 0)
                    chk($sformatf("rr_space%0d", g), (cyc - last_s) >= 4,
                        $sformatf("%0d cycles", cyc - last_s), ">=4 cycles");
                last_s = cyc;
                tick();
                tick();
                done_i = 1'b1;
                tick();
                done_i = 1'b0;
            end
        end
        req_i = '0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1);
    end

endmodule

// File: doc/task_sched.md
Name: task_sched

Overview:
- Round-robin scheduler between the 16-bit task request register and one shared single-threaded task engine (e.g. the serial config/readout engine).
- Picks one pending request and raises the matching ack bit for the whole execution, so the task register drops req; pulses start to the engine with the task index.
- Drops ack when the engine reports done or a watchdog expires; that falling ack clears the task's valid bit in the task register.

Parameters:
- N_TASK, 16: number of task lines; fixed at 16, ID width 4.
- TMO_W, 16: watchdog counter width.
- P_TIMEOUT, 16'd50000: watchdog limit in clk cycles; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  16  task requests from the task register, level.
- en  input  16  per-task enable mask; a masked request stays pending and is never granted.
- ack  output  16  one-hot or zero; high for the granted task through execution.
- start  output  1  one-cycle pulse telling the engine to begin task task_id.
- task_id  output  4  index of the granted task; valid while busy.
- busy  output  1  high from the start cycle through the RELEASE cycle.
- done  input  1  engine completion pulse.
- abort  output  1  one-cycle pulse on watchdog expiry; the engine must return to idle.
- tmo_err  output  1  sticky watchdog error flag.
- tmo_id  output  4  task_id captured at the last timeout.
- err_clr  input  1  clears tmo_err.

Behaviour:
- Reset: asynchronous on rst_n low; takes effect immediately, mid-task included.
  - Reset values: ack=0, start=0, abort=0, busy=0, task_id=0, tmo_err=0, tmo_id=0, state=IDLE, rr_ptr=15, watchdog count=0.
  - Dropping ack on reset is intentional: the task register sees an ack falling edge and retires the task.
- All outputs are registered.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Candidate set c = req & en.
  - If c is nonzero, select the first set bit searching rr_ptr+1, rr_ptr+2, ... with wrap-around 15->0.
  - Next edge: ack <= onehot(sel), start <= 1, task_id <= sel, rr_ptr <= sel, count <= 0, busy <= 1, state <= BUSY.
  - Latency: req high in cycle n gives ack/start high in cycle n+1.
  - If c is zero, stay in IDLE with outputs quiescent.
- BUSY:
  - start <= 0 after its single cycle; ack is held.
  - done is ignored in the cycle start is high; after that, done=1 makes ack <= 0 and state <= RELEASE.
  - Watchdog: count increments each BUSY cycle, saturating.
  - If P_TIMEOUT != 0 and count == P_TIMEOUT-1 with no done that cycle: ack <= 0, abort <= 1 (one cycle), tmo_err <= 1, tmo_id <= task_id, state <= RELEASE.
  - done and timeout in the same cycle: done wins, no error.
  - Changes to req or en during BUSY do not affect the running task.
- RELEASE:
  - Exactly one cycle with ack=0 and busy=1; then busy <= 0 and state <= IDLE.
  - Guarantees ack low for at least 2 cycles before any new grant, so the task register sees the falling edge and its req/val for the finished task are already cleared.
  - A task is therefore never re-granted on a stale req.
- Fairness:
  - Granted index becomes lowest priority next round.
  - With all 16 pending, service order is ptr+1 ... ptr with wrap; no starvation.
  - Grant-to-grant minimum spacing: start, >=1 BUSY cycle, RELEASE, IDLE = 4 cycles when done arrives on the first eligible cycle.
- tmo_err: err_clr clears it; err_clr and a new timeout in the same cycle leaves it set; tmo_id only updates on a timeout.
- done received in IDLE or RELEASE is ignored.

Test Plan:
- Single task: en=16'hFFFF, req=16'h0004 at cycle 0 -> cycle 1 ack=16'h0004, start=1, task_id=2; done at cycle 5 -> cycle 6 ack=0, RELEASE; cycle 7 busy=0; no second grant even if req stays high for 1 cycle after the ack edge.
- Round-robin: req=16'h8101 held, done 2 cycles after each start -> grant order 0, 8, 15, 0, 8; each start separated by >=4 cycles.
- Mask: req=16'h0003, en=16'h0002 -> only task 1 granted; set en=16'hFFFF later -> task 0 granted next.
- Watchdog: P_TIMEOUT=8, req=16'h0010, no done -> ack low and abort=1 exactly 8 cycles after start; tmo_err=1, tmo_id=4; err_clr pulse -> tmo_err=0; err_clr in the same cycle as a second timeout -> tmo_err stays 1.
- Done/timeout collision: P_TIMEOUT=8, done on the 8th BUSY cycle -> tmo_err stays 0, abort stays 0, normal RELEASE; done during the start cycle -> ignored.
- Reset mid-task: rst_n low while BUSY with ack=16'h0100 -> ack=0, busy=0 asynchronously before the next edge; after release, rr_ptr=15 and req=16'hFFFF grants task 0 first.
